// File: rtl/multicycle_main_decoder_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes,
// data-processing commands and datapath mux selects.
package multicycle_main_decoder_pkg;
  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_RD1    = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
endpackage

// File: rtl/multicycle_main_decoder_alu_decoder.sv
// Combinational ALU decoder: maps ALUOp and Funct to ALU operation,
// flag-write enables and the CMP/unknown-command write suppression.
module alu_decoder
  import multicycle_main_decoder_pkg::*;
(
  input  logic       i_alu_op,
  input  logic [5:0] i_funct,
  output logic [1:0] o_alu_control,
  output logic [1:0] o_flag_w,
  output logic       o_no_write
);
  logic [3:0] w_cmd;
  logic       w_s;
  assign w_cmd = i_funct[4:1];
  assign w_s   = i_funct[0];

  always_comb begin
    o_alu_control = ALU_ADD;
    o_flag_w      = 2'b00;
    o_no_write    = 1'b0;
    if (i_alu_op) begin
      case (w_cmd)
        CMD_ADD: begin o_alu_control = ALU_ADD; o_flag_w = {w_s, w_s}; end
        CMD_SUB: begin o_alu_control = ALU_SUB; o_flag_w = {w_s, w_s}; end
        CMD_AND: begin o_alu_control = ALU_AND; o_flag_w = {w_s, 1'b0}; end
        CMD_ORR: begin o_alu_control = ALU_ORR; o_flag_w = {w_s, 1'b0}; end
        CMD_CMP: begin
          o_alu_control = ALU_SUB;
          o_flag_w      = {w_s, w_s};
          o_no_write    = 1'b1;
        end
        // Unsupported commands execute as a harmless add with no writeback.
        default: o_no_write = 1'b1;
      endcase
    end
  end
endmodule

// File: rtl/multicycle_main_decoder.sv
// Multicycle ARM-subset controller: Moore FSM driving datapath selects and
// raw write requests, plus the ALU decoder for data-processing instructions.
module multicycle_main_decoder
  import multicycle_main_decoder_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_op,
  input  logic [5:0] i_funct,
  input  logic [3:0] i_rd,
  output logic       o_pcs,
  output logic       o_reg_w,
  output logic       o_mem_w,
  output logic       o_no_write,
  output logic [1:0] o_flag_w,
  output logic       o_ir_write,
  output logic       o_next_pc,
  output logic       o_adr_src,
  output logic [1:0] o_result_src,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_alu_control
);
  state_t r_state, w_next, w_dec_state;
  logic   w_alu_op, w_pcs, w_reg_w, w_mem_w, w_ir_write, w_next_pc;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_FETCH;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (i_op)
          OP_MEM:  w_next = S_MEMADR;
          OP_DP:   w_next = i_funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR:   w_next = i_funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    w_next = S_MEMWB;
      S_EXECUTER,
      S_EXECUTEI: w_next = S_ALUWB;
      default:    w_next = S_FETCH;
    endcase
  end

  // During reset the outputs decode as FETCH, with the write strobes masked below.
  assign w_dec_state = i_reset ? S_FETCH : r_state;

  always_comb begin
    w_ir_write   = 1'b0;
    w_next_pc    = 1'b0;
    w_reg_w      = 1'b0;
    w_mem_w      = 1'b0;
    w_pcs        = 1'b0;
    w_alu_op     = 1'b0;
    o_adr_src    = 1'b0;
    o_result_src = RES_ALUOUT;
    o_alu_src_a  = SRCA_RD1;
    o_alu_src_b  = SRCB_RD2;
    case (w_dec_state)
      S_FETCH: begin
        w_ir_write   = 1'b1;
        w_next_pc    = 1'b1;
        o_alu_src_a  = SRCA_PC;
        o_alu_src_b  = SRCB_FOUR;
        o_result_src = RES_ALURES;
      end
      S_DECODE: begin
        o_alu_src_a  = SRCA_PC;
        o_alu_src_b  = SRCB_FOUR;
        o_result_src = RES_ALURES;
      end
      S_MEMADR: o_alu_src_b = SRCB_IMM;
      S_MEMRD:  o_adr_src   = 1'b1;
      S_MEMWB: begin
        o_result_src = RES_DATA;
        w_reg_w      = 1'b1;
        w_pcs        = (i_rd == 4'd15);
      end
      S_MEMWR: begin
        o_adr_src = 1'b1;
        w_mem_w   = 1'b1;
      end
      S_EXECUTER: w_alu_op = 1'b1;
      S_EXECUTEI: begin
        w_alu_op    = 1'b1;
        o_alu_src_b = SRCB_IMM;
      end
      // ALUOp stays high so FlagW/NoWrite remain valid for the writeback.
      S_ALUWB: begin
        w_alu_op = 1'b1;
        w_reg_w  = 1'b1;
        w_pcs    = (i_rd == 4'd15);
      end
      S_BRANCH: begin
        o_alu_src_a  = SRCA_ALUOUT;
        o_alu_src_b  = SRCB_IMM;
        o_result_src = RES_ALURES;
        w_pcs        = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_ir_write = w_ir_write & ~i_reset;
  assign o_next_pc  = w_next_pc  & ~i_reset;
  assign o_reg_w    = w_reg_w    & ~i_reset;
  assign o_mem_w    = w_mem_w    & ~i_reset;
  assign o_pcs      = w_pcs      & ~i_reset;

  alu_decoder u_alu_dec (
    .i_alu_op     (w_alu_op),
    .i_funct      (i_funct),
    .o_alu_control(o_alu_control),
    .o_flag_w     (o_flag_w),
    .o_no_write   (o_no_write)
  );
endmodule
